hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- ID-stage pipeline hazard controller.
- Keeps a two-entry scoreboard of in-flight writers (EX, MEM) and drives the hazard flags consumed by the ID-stage forwarding mux.
- Generates load-use stalls and sequences a multi-cycle HI/LO multiply/divide unit, stalling ID while HI/LO results are not ready.
- Sits beside the ID/EX pipeline register; drives IF/ID hold, ID/EX bubble insertion and md_start.

Parameters:
DIV_CYCLES, 32, cycles the divider is busy after start (>=2)
MUL_CYCLES, 4, cycles the multiplier is busy after start (>=2)
CNT_W, 6, busy-counter width; must hold max(DIV_CYCLES, MUL_CYCLES)

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_rs  in  5  ID source register rs
id_rt  in  5  ID source register rt
id_use_rs  in  1  instruction reads rs
id_use_rt  in  1  instruction reads rt
id_rf_we  in  1  instruction writes the register file
id_rf_wd  in  5  destination register
id_rf_wsel  in  3  writeback source code (WB_ALU..WB_PC8)
id_is_mult  in  1  MULT/MULTU in ID
id_is_div  in  1  DIV/DIVU in ID
id_hilo_wr  in  1  MTHI/MTLO in ID
id_ex_hazard_mem  out  1  EX load targets a used source: load-use
id_ex_rs_hazard_reg  out  1  EX non-load writer targets rs
id_ex_rt_hazard_reg  out  1  EX non-load writer targets rt
id_mem_rs_hazard_mem  out  1  MEM load targets rs
id_mem_rs_hazard_reg  out  1  MEM non-load writer targets rs
id_mem_rt_hazard_mem  out  1  MEM load targets rt
id_mem_rt_hazard_reg  out  1  MEM non-load writer targets rt
stall_if  out  1  hold PC
stall_id  out  1  hold IF/ID
bubble_ex  out  1  load NOP into ID/EX
md_start  out  1  one-cycle start pulse to mult/div unit
md_busy  out  1  mult/div unit busy

Behaviour:
Reset is asynchronous and active-low (resetn), clocked on clk rising edge. On reset:
- scoreboard entries invalid
- FSM = IDLE, counter = 0
- every output 0

Scoreboard:
- Entries EX{v,we,wd,wsel} and MEM{v,we,wd,wsel}.
- Each cycle: MEM <= EX.
- EX <= ID fields when id_valid & ~stall_id; otherwise EX <= bubble (v=0).
- Entry "matches" register r only when v & we & wd==r & r!=0.

Hazard flags (combinational from the scoreboard and ID inputs):
- id_ex_hazard_mem = EX matches a used source (id_use_rs/id_use_rt) & EX.wsel==WB_RAM.
- id_ex_rs_hazard_reg = EX matches rs & id_use_rs & EX.wsel!=WB_RAM; rt analogous.
- MEM flags use the same rules on the MEM entry.
- An EX match masks the MEM flag for the same source; the youngest writer wins.
- All flags are 0 when id_valid=0.

Stall sources:
- load-use: id_ex_hazard_mem. Lasts exactly 1 cycle; the next cycle the load is in MEM and the _mem_hazard_mem flag fires instead.
- md-hazard: FSM != IDLE and the ID instruction either has rf_wsel in {WB_HI, WB_LO}, is a new mult/div, or has id_hilo_wr.
- stall_if = stall_id = bubble_ex = load-use | md-hazard.

Mult/div FSM (states IDLE, MUL_BUSY, DIV_BUSY):
- IDLE: when id_valid & (id_is_mult|id_is_div) & ~stall_id, pulse md_start for that cycle.
  - Next state MUL_BUSY or DIV_BUSY; counter <= MUL_CYCLES-1 or DIV_CYCLES-1 respectively.
  - If both is_mult and is_div are set, div takes priority.
- BUSY: counter decrements each cycle; md_busy=1. At counter==0, next state is IDLE.
- The stall drops the same cycle the FSM reaches IDLE, so a HI/LO read in ID proceeds in the first cycle after BUSY ends.
- Counter arithmetic is unsigned CNT_W bits with no wrap; the counter is never decremented below 0.

Simultaneous events:
- A load-use stall in the same cycle as an md start suppresses md_start; the start is re-evaluated next cycle.
- resetn low mid-division returns to IDLE immediately and clears md_busy; the datapath discards its partial result.

Decomposition:
- Shared package cpu_defs: WB_* codes (WB_ALU=001, WB_RS=010, WB_RAM=011, WB_HI=100, WB_LO=101, WB_PC8=110) and the FSM state encoding (IDLE=2'b00, MUL_BUSY=2'b01, DIV_BUSY=2'b10).
- One sub-module: md_seq, containing the FSM and busy counter, which outputs md_start, md_busy and the md-hazard term.

Test Plan:
- LW $2 then ADD $3,$2,$4: 1 cycle with id_ex_hazard_mem=1, stall_if=stall_id=bubble_ex=1; next cycle id_mem_rs_hazard_mem=1 and no stall.
- ADDU $5,.. then SUB $6,$5,$5: id_ex_rs_hazard_reg=id_ex_rt_hazard_reg=1, no stall; with a NOP inserted between them, id_mem_rs_hazard_reg=1 instead.
- ADDU $0,.. then ADD $7,$0,$0: all hazard flags 0.
- Two writers: ADDU $8 then ORI $8 then use $8: only the EX flag asserts; the MEM flag is masked.
- DIV followed immediately by MFLO: md_start pulses 1 cycle, stall held for DIV_CYCLES=32 cycles, MFLO issues on cycle 33; with MUL_CYCLES=4 the same pattern holds for 4 cycles.
- DIV, then resetn low at busy cycle 10: md_busy and stall drop asynchronously; after release the FSM is IDLE and the scoreboard is empty.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared CPU definitions for the ID-stage hazard logic.
//   - WB_* writeback source codes carried with each in-flight writer
//   - md_state_e : mult/div sequencer state encoding
//   - sb_entry_t : one scoreboard entry (EX or MEM writer)
//   - sb_match() : does an entry write a given (non-zero) register
package cpu_defs;

  localparam logic [2:0] WB_ALU = 3'b001;
  localparam logic [2:0] WB_RS  = 3'b010;
  localparam logic [2:0] WB_RAM = 3'b011;
  localparam logic [2:0] WB_HI  = 3'b100;
  localparam logic [2:0] WB_LO  = 3'b101;
  localparam logic [2:0] WB_PC8 = 3'b110;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    MUL_BUSY = 2'b01,
    DIV_BUSY = 2'b10
  } md_state_e;

  typedef struct packed {
    logic       v;
    logic       we;
    logic [4:0] wd;
    logic [2:0] wsel;
  } sb_entry_t;

  // $0 is hard-wired to zero, so a write to it never creates a dependency.
  function automatic logic sb_match(input sb_entry_t e, input logic [4:0] r);
    return e.v & e.we & (e.wd == r) & (r != 5'd0);
  endfunction

endpackage

// File: rtl/md_seq.sv
// Mult/div sequencer: tracks how long the multi-cycle HI/LO unit is busy.
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   id_valid           ID holds a real instruction
//   id_rf_wsel         ID writeback source (HI/LO reads stall while busy)
//   id_is_mult/div     ID holds MULT(U)/DIV(U)
//   id_hilo_wr         ID holds MTHI/MTLO
//   load_use           load-use stall this cycle (blocks a new start)
//   md_start           one-cycle start pulse
//   md_busy            unit busy
//   md_hazard          ID instruction must wait for the unit
module md_seq
  import cpu_defs::*;
#(
  parameter int unsigned DIV_CYCLES = 32,
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned CNT_W      = 6
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       id_valid,
  input  logic [2:0] id_rf_wsel,
  input  logic       id_is_mult,
  input  logic       id_is_div,
  input  logic       id_hilo_wr,
  input  logic       load_use,
  output logic       md_start,
  output logic       md_busy,
  output logic       md_hazard
);

  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign md_busy   = (state_q != IDLE);
  assign md_hazard = md_busy & id_valid &
                     ((id_rf_wsel == WB_HI) | (id_rf_wsel == WB_LO) |
                      id_is_mult | id_is_div | id_hilo_wr);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    md_start = 1'b0;
    case (state_q)
      IDLE: begin
        // In IDLE the only stall source is load-use, so ~load_use == ~stall_id.
        // resetn gating keeps the pulse low while reset is held.
        if (resetn & id_valid & (id_is_mult | id_is_div) & ~load_use) begin
          md_start = 1'b1;
          if (id_is_div) begin
            state_d = DIV_BUSY;
            cnt_d   = DIV_LOAD;
          end else begin
            state_d = MUL_BUSY;
            cnt_d   = MUL_LOAD;
          end
        end
      end
      MUL_BUSY, DIV_BUSY: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// ID-stage hazard controller.
// Keeps a two-entry scoreboard (EX, MEM) of in-flight register writers,
// drives forwarding hazard flags, load-use stalls and mult/div sequencing.
// Ports:
//   clk, resetn                     clock, asynchronous active-low reset
//   id_*                            decoded fields of the ID instruction
//   id_ex_* / id_mem_*              hazard flags for the ID forwarding mux
//   stall_if, stall_id, bubble_ex   pipeline hold / bubble controls
//   md_start, md_busy               mult/div unit control and status
module hazard_ctrl
  import cpu_defs::*;
#(
  parameter int unsigned DIV_CYCLES = 32,
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned CNT_W      = 6
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       id_rf_we,
  input  logic [4:0] id_rf_wd,
  input  logic [2:0] id_rf_wsel,
  input  logic       id_is_mult,
  input  logic       id_is_div,
  input  logic       id_hilo_wr,
  output logic       id_ex_hazard_mem,
  output logic       id_ex_rs_hazard_reg,
  output logic       id_ex_rt_hazard_reg,
  output logic       id_mem_rs_hazard_mem,
  output logic       id_mem_rs_hazard_reg,
  output logic       id_mem_rt_hazard_mem,
  output logic       id_mem_rt_hazard_reg,
  output logic       stall_if,
  output logic       stall_id,
  output logic       bubble_ex,
  output logic       md_start,
  output logic       md_busy
);

  sb_entry_t ex_q, ex_d, mem_q;
  logic      ex_rs_m, ex_rt_m, mem_rs_m, mem_rt_m;
  logic      ex_is_load, mem_is_load;
  logic      load_use, md_hazard, stall;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ex_q  <= '0;
      mem_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
    end
  end

  // A stalled ID instruction stays in ID, so EX receives a bubble.
  always_comb begin
    ex_d = '0;
    if (id_valid & ~stall) begin
      ex_d = '{v: 1'b1, we: id_rf_we, wd: id_rf_wd, wsel: id_rf_wsel};
    end
  end

  assign ex_rs_m     = sb_match(ex_q, id_rs) & id_use_rs;
  assign ex_rt_m     = sb_match(ex_q, id_rt) & id_use_rt;
  // The younger EX writer hides the MEM writer of the same source.
  assign mem_rs_m    = sb_match(mem_q, id_rs) & id_use_rs & ~ex_rs_m;
  assign mem_rt_m    = sb_match(mem_q, id_rt) & id_use_rt & ~ex_rt_m;
  assign ex_is_load  = (ex_q.wsel == WB_RAM);
  assign mem_is_load = (mem_q.wsel == WB_RAM);

  assign id_ex_hazard_mem     = id_valid & (ex_rs_m | ex_rt_m) & ex_is_load;
  assign id_ex_rs_hazard_reg  = id_valid & ex_rs_m & ~ex_is_load;
  assign id_ex_rt_hazard_reg  = id_valid & ex_rt_m & ~ex_is_load;
  assign id_mem_rs_hazard_mem = id_valid & mem_rs_m & mem_is_load;
  assign id_mem_rs_hazard_reg = id_valid & mem_rs_m & ~mem_is_load;
  assign id_mem_rt_hazard_mem = id_valid & mem_rt_m & mem_is_load;
  assign id_mem_rt_hazard_reg = id_valid & mem_rt_m & ~mem_is_load;

  assign load_use  = id_ex_hazard_mem;
  assign stall     = load_use | md_hazard;
  assign stall_if  = stall;
  assign stall_id  = stall;
  assign bubble_ex = stall;

  md_seq #(
    .DIV_CYCLES(DIV_CYCLES),
    .MUL_CYCLES(MUL_CYCLES),
    .CNT_W     (CNT_W)
  ) u_md_seq (
    .clk       (clk),
    .resetn    (resetn),
    .id_valid  (id_valid),
    .id_rf_wsel(id_rf_wsel),
    .id_is_mult(id_is_mult),
    .id_is_div (id_is_div),
    .id_hilo_wr(id_hilo_wr),
    .load_use  (load_use),
    .md_start  (md_start),
    .md_busy   (md_busy),
    .md_hazard (md_hazard)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a driver feeds instructions and a
// high-level pipeline model pushes the expected outputs; a monitor pops
// and compares every cycle.
module tb_hazard_ctrl;

  localparam int DIVC = 32;
  localparam int MULC = 4;
  localparam bit [2:0] W_ALU = 3'b001;
  localparam bit [2:0] W_RAM = 3'b011;
  localparam bit [2:0] W_HI  = 3'b100;
  localparam bit [2:0] W_LO  = 3'b101;

  logic clk = 1'b0;
  logic resetn;
  logic id_valid, id_use_rs, id_use_rt, id_rf_we;
  logic [4:0] id_rs, id_rt, id_rf_wd;
  logic [2:0] id_rf_wsel;
  logic id_is_mult, id_is_div, id_hilo_wr;
  logic id_ex_hazard_mem, id_ex_rs_hazard_reg, id_ex_rt_hazard_reg;
  logic id_mem_rs_hazard_mem, id_mem_rs_hazard_reg;
  logic id_mem_rt_hazard_mem, id_mem_rt_hazard_reg;
  logic stall_if, stall_id, bubble_ex, md_start, md_busy;

  always #5 clk = ~clk;

  hazard_ctrl #(.DIV_CYCLES(DIVC), .MUL_CYCLES(MULC), .CNT_W(6)) dut (
    .clk(clk), .resetn(resetn),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_rf_we(id_rf_we), .id_rf_wd(id_rf_wd), .id_rf_wsel(id_rf_wsel),
    .id_is_mult(id_is_mult), .id_is_div(id_is_div), .id_hilo_wr(id_hilo_wr),
    .id_ex_hazard_mem(id_ex_hazard_mem),
    .id_ex_rs_hazard_reg(id_ex_rs_hazard_reg),
    .id_ex_rt_hazard_reg(id_ex_rt_hazard_reg),
    .id_mem_rs_hazard_mem(id_mem_rs_hazard_mem),
    .id_mem_rs_hazard_reg(id_mem_rs_hazard_reg),
    .id_mem_rt_hazard_mem(id_mem_rt_hazard_mem),
    .id_mem_rt_hazard_reg(id_mem_rt_hazard_reg),
    .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex),
    .md_start(md_start), .md_busy(md_busy)
  );

  typedef struct {
    bit       valid;
    bit [4:0] rs, rt;
    bit       use_rs, use_rt, we;
    bit [4:0] wd;
    bit [2:0] wsel;
    bit       mult, div, hwr;
  } inst_t;

  int tests = 0;
  int fails = 0;
  bit [11:0] exp_q[$];

  // Model state: instructions that left ID, newest first; cycle until which
  // the mult/div unit is still busy.
  inst_t hist[$];
  int    busy_until = -1;
  int    cyc = 0;

  function automatic inst_t nop();
    inst_t i;
    i = '{default: 0};
    return i;
  endfunction

  function automatic inst_t rtype(input bit [4:0] d, input bit [4:0] s, input bit [4:0] t);
    inst_t i;
    i = nop();
    i.valid = 1; i.rs = s; i.rt = t; i.use_rs = 1; i.use_rt = 1;
    i.we = 1; i.wd = d; i.wsel = W_ALU;
    return i;
  endfunction

  function automatic inst_t itype(input bit [4:0] d, input bit [4:0] s, input bit [2:0] ws);
    inst_t i;
    i = rtype(d, s, 5'd0);
    i.use_rt = 0; i.wsel = ws;
    return i;
  endfunction

  function automatic inst_t mdop(input bit is_div);
    inst_t i;
    i = rtype(5'd0, 5'd1, 5'd2);
    i.we = 0; i.div = is_div; i.mult = !is_div;
    return i;
  endfunction

  function automatic inst_t mflo(input bit [4:0] d);
    inst_t i;
    i = itype(d, 5'd0, W_LO);
    i.use_rs = 0;
    return i;
  endfunction

  function automatic bit writes(input inst_t e, input bit [4:0] r);
    return e.valid && e.we && e.wd == r && r != 0;
  endfunction

  function automatic bit [11:0] dut_vec();
    return {id_ex_hazard_mem, id_ex_rs_hazard_reg, id_ex_rt_hazard_reg,
            id_mem_rs_hazard_mem, id_mem_rs_hazard_reg,
            id_mem_rt_hazard_mem, id_mem_rt_hazard_reg,
            stall_if, stall_id, bubble_ex, md_start, md_busy};
  endfunction

  task automatic drive(input inst_t i);
    id_valid = i.valid; id_rs = i.rs; id_rt = i.rt;
    id_use_rs = i.use_rs; id_use_rt = i.use_rt; id_rf_we = i.we;
    id_rf_wd = i.wd; id_rf_wsel = i.wsel;
    id_is_mult = i.mult; id_is_div = i.div; id_hilo_wr = i.hwr;
  endtask

  // One ID cycle: drive the instruction and push what the model expects.
  task automatic step(input inst_t i, output bit exp_stall);
    inst_t ex, mem, acc;
    bit ers, ert, mrs, mrt, exl, meml, lu, busy, mdh, st, start;
    @(negedge clk);
    drive(i);
    ex  = (hist.size() > 0) ? hist[0] : nop();
    mem = (hist.size() > 1) ? hist[1] : nop();
    ers = i.valid && i.use_rs && writes(ex, i.rs);
    ert = i.valid && i.use_rt && writes(ex, i.rt);
    mrs = i.valid && i.use_rs && writes(mem, i.rs) && !writes(ex, i.rs);
    mrt = i.valid && i.use_rt && writes(mem, i.rt) && !writes(ex, i.rt);
    exl  = (ex.wsel == W_RAM);
    meml = (mem.wsel == W_RAM);
    lu   = (ers || ert) && exl;
    busy = (cyc <= busy_until);
    mdh  = busy && i.valid && (i.wsel == W_HI || i.wsel == W_LO || i.mult || i.div || i.hwr);
    st   = lu || mdh;
    start = !busy && i.valid && (i.mult || i.div) && !st;
    if (start) busy_until = cyc + (i.div ? DIVC : MULC);
    exp_q.push_back({lu, ers && !exl, ert && !exl, mrs && meml, mrs && !meml,
                     mrt && meml, mrt && !meml, st, st, st, start, busy});
    acc = i;
    acc.valid = i.valid && !st;
    hist.push_front(acc);
    if (hist.size() > 2) void'(hist.pop_back());
    cyc++;
    exp_stall = st;
  endtask

  // Monitor: outputs are valid every cycle; compare mid-low-phase.
  int mon_n = 0;
  bit [11:0] mon_exp, mon_act;
  always @(negedge clk) begin
    #2;
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_act = dut_vec();
      tests++;
      if (mon_act !== mon_exp) begin
        fails++;
        $display("FAIL cycle_outputs n=%0d act=%b exp=%b", mon_n, mon_act, mon_exp);
      end else begin
        $display("[MON] n=%0d outputs=%b ok", mon_n, mon_act);
      end
      mon_n++;
    end
  end

  task automatic check(input string name, input bit [11:0] act, input bit [11:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end else begin
      $display("[CHK] %s = %0d ok", name, act);
    end
  endtask

  task automatic md_latency(input bit is_div, input string name, input int exp_n);
    bit st;
    int n;
    step(mdop(is_div), st);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      step(mflo(5'd9), st);
      #1;
      if (!stall_id) break;
      n++;
    end
    check(name, 12'(n), 12'(exp_n));
  endtask

  initial begin
    bit st;
    inst_t r;
    resetn = 1'b0;
    drive(nop());
    #1;
    check("reset_outputs", dut_vec(), 12'd0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;

    // Load-use: one stall cycle, then the MEM load flag.
    step(itype(5'd2, 5'd1, W_RAM), st);
    step(rtype(5'd3, 5'd2, 5'd4), st);
    #1 check("load_use_stall", 12'(stall_id), 12'd1);
    step(rtype(5'd3, 5'd2, 5'd4), st);
    #1 check("load_use_mem_flag", 12'(id_mem_rs_hazard_mem), 12'd1);
    check("load_use_released", 12'(stall_id), 12'd0);

    // EX then MEM forwarding of an ALU result.
    step(rtype(5'd5, 5'd1, 5'd1), st);
    step(rtype(5'd6, 5'd5, 5'd5), st);
    step(rtype(5'd5, 5'd1, 5'd1), st);
    step(nop(), st);
    step(rtype(5'd6, 5'd5, 5'd5), st);
    // $0 writer never hazards.
    step(rtype(5'd0, 5'd1, 5'd1), st);
    step(rtype(5'd7, 5'd0, 5'd0), st);
    // Two writers of $8: youngest wins.
    step(rtype(5'd8, 5'd1, 5'd1), st);
    step(itype(5'd8, 5'd9, W_ALU), st);
    step(rtype(5'd10, 5'd8, 5'd8), st);
    #1 check("mem_masked_by_ex", 12'({id_ex_rs_hazard_reg, id_mem_rs_hazard_reg}), 12'd2);

    md_latency(1'b1, "div_stall_cycles", DIVC);
    md_latency(1'b0, "mul_stall_cycles", MULC);

    // Reset in the middle of a division.
    step(mdop(1'b1), st);
    repeat (10) step(mflo(5'd11), st);
    @(negedge clk);
    #3 resetn = 1'b0;
    #1 check("async_reset_outputs", dut_vec(), 12'd0);
    hist.delete();
    busy_until = -1;
    @(negedge clk);
    drive(nop());
    @(negedge clk);
    resetn = 1'b1;
    step(mflo(5'd11), st);
    step(rtype(5'd12, 5'd11, 5'd11), st);

    // Randomised traffic over a small register window to provoke hazards.
    for (int k = 0; k < 800; k++) begin
      r = nop();
      r.valid  = ($urandom_range(7) != 0);
      r.rs     = 5'($urandom_range(5));
      r.rt     = 5'($urandom_range(5));
      r.use_rs = 1'($urandom_range(1));
      r.use_rt = 1'($urandom_range(1));
      r.we     = 1'($urandom_range(1));
      r.wd     = 5'($urandom_range(5));
      r.wsel   = 3'($urandom_range(6, 1));
      r.mult   = ($urandom_range(19) == 0);
      r.div    = ($urandom_range(29) == 0);
      r.hwr    = ($urandom_range(19) == 0);
      step(r, st);
    end

    repeat (2) @(negedge clk);
    #3 check("scoreboard_drained", 12'(exp_q.size()), 12'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
